// File: rtl/weight_pingpong_if.sv
// Handshake and status bundle between the weight loader / top FSM and the
// ping-pong weight-memory address controller.
interface weight_pingpong_if #(
  parameter int unsigned WR_ADDR_DEPTH = 10,
  parameter int unsigned RD_ADDR_DEPTH = 8,
  parameter int unsigned REP_W         = 4
);
  logic [2:0]               current_state;
  logic [WR_ADDR_DEPTH-1:0] cfg_wr_len;
  logic [RD_ADDR_DEPTH-1:0] cfg_rd_len;
  logic [REP_W-1:0]         cfg_rd_rep;
  logic                     wr_valid;
  logic                     wr_ready;
  logic                     wr_en;
  logic [WR_ADDR_DEPTH-1:0] addr_wr;
  logic                     wr_bank;
  logic                     rd_ready;
  logic                     rd_en;
  logic [RD_ADDR_DEPTH-1:0] addr_rd;
  logic                     rd_bank;
  logic                     weight_valid_rd;
  logic                     load_done;
  logic                     state_rst;
  logic [1:0]               bank_full;

  modport master (
    output current_state, cfg_wr_len, cfg_rd_len, cfg_rd_rep, wr_valid, rd_ready,
    input  wr_ready, wr_en, addr_wr, wr_bank, rd_en, addr_rd, rd_bank,
           weight_valid_rd, load_done, state_rst, bank_full
  );

  modport slave (
    input  current_state, cfg_wr_len, cfg_rd_len, cfg_rd_rep, wr_valid, rd_ready,
    output wr_ready, wr_en, addr_wr, wr_bank, rd_en, addr_rd, rd_bank,
           weight_valid_rd, load_done, state_rst, bank_full
  );
endinterface

// File: rtl/weight_pingpong_ctrl.sv
// Weight DRM ping/pong address controller: fills one bank while the PE array replays the other.
// Define WEIGHT_PINGPONG_EN for two banks; otherwise a single bank serializes loads and reads.
module weight_pingpong_ctrl #(
  parameter int unsigned WR_ADDR_DEPTH = 10,
  parameter int unsigned RD_ADDR_DEPTH = 8,
  parameter int unsigned REP_W         = 4,
  parameter int unsigned RD_LAT        = 1,
  parameter logic [2:0]  CONV_STATE    = 3'd2
) (
  input  logic             clk,
  input  logic             rst,
  weight_pingpong_if.slave bus
);

  logic [WR_ADDR_DEPTH-1:0] addr_wr;
  logic [RD_ADDR_DEPTH-1:0] addr_rd;
  logic [REP_W-1:0]         pass_cnt;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  logic [RD_LAT-1:0]        valid_pipe;
  logic [RD_LAT-1:0]        last_pipe;
  logic                     load_done;
  logic                     wr_ready;
  logic                     wr_en;
  logic                     rd_en;
  logic                     wr_last;
  logic                     rd_last_word;
  logic                     rd_done;

  assign wr_ready     = ~full[wr_bank];
  assign wr_en        = bus.wr_valid & wr_ready;
  assign rd_en        = (bus.current_state == CONV_STATE) & full[rd_bank] & bus.rd_ready;
  assign wr_last      = wr_en & (addr_wr == bus.cfg_wr_len);
  assign rd_last_word = (addr_rd >= bus.cfg_rd_len);
  assign rd_done      = rd_en & rd_last_word & (pass_cnt >= bus.cfg_rd_rep);

  // Write offset and end-of-fill pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_wr   <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= wr_last;
      if (wr_en) begin
        addr_wr <= wr_last ? '0 : addr_wr + WR_ADDR_DEPTH'(1);
      end
    end
  end

  // Read offset sweeps a pass; the pass counter replays the bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_rd  <= '0;
      pass_cnt <= '0;
    end else if (rd_en) begin
      if (!rd_last_word) begin
        addr_rd <= addr_rd + RD_ADDR_DEPTH'(1);
      end else begin
        addr_rd  <= '0;
        pass_cnt <= rd_done ? '0 : pass_cnt + REP_W'(1);
      end
    end
  end

  // Set and clear always hit different banks, so both may apply in one cycle
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
`ifndef WEIGHT_PINGPONG_EN
    full_nxt[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      full <= full_nxt;
    end
  end

`ifdef WEIGHT_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (wr_last) wr_bank <= ~wr_bank;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  // Valid and end-of-bank tag travel alongside the RAM read latency; bubbles shift through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      valid_pipe[0] <= rd_en;
      last_pipe[0]  <= rd_done;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  assign bus.wr_ready        = wr_ready;
  assign bus.wr_en           = wr_en;
  assign bus.addr_wr         = addr_wr;
  assign bus.wr_bank         = wr_bank;
  assign bus.rd_en           = rd_en;
  assign bus.addr_rd         = addr_rd;
  assign bus.rd_bank         = rd_bank;
  assign bus.weight_valid_rd = valid_pipe[RD_LAT-1];
  assign bus.state_rst       = last_pipe[RD_LAT-1];
  assign bus.load_done       = load_done;
  assign bus.bank_full       = full;

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Directed bench for weight_pingpong_ctrl (RD_LAT=2); expectations adapt to WEIGHT_PINGPONG_EN.
module tb_weight_pingpong_ctrl;

`ifdef WEIGHT_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  weight_pingpong_if #(.WR_ADDR_DEPTH(10), .RD_ADDR_DEPTH(8), .REP_W(4)) bus ();

  weight_pingpong_ctrl #(
    .WR_ADDR_DEPTH(10), .RD_ADDR_DEPTH(8), .REP_W(4), .RD_LAT(2), .CONV_STATE(3'd2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_addr_wr", 32'(bus.addr_wr), 0);
    chk("rst_addr_rd", 32'(bus.addr_rd), 0);
    chk("rst_wr_bank", 32'(bus.wr_bank), 0);
    chk("rst_rd_bank", 32'(bus.rd_bank), 0);
    chk("rst_bank_full", 32'(bus.bank_full), 0);
    chk("rst_valid", 32'(bus.weight_valid_rd), 0);
    chk("rst_load_done", 32'(bus.load_done), 0);
    chk("rst_state_rst", 32'(bus.state_rst), 0);
    chk("rst_wr_ready", 32'(bus.wr_ready), 1);
    chk("rst_rd_en", 32'(bus.rd_en), 0);
  endtask

  initial begin
    logic [7:0] rr_tab, wv_tab, sr_tab, wrdy_tab;
    int         ard_tab [8];
    rr_tab   = 8'b00011101;
    wv_tab   = 8'b01110100;
    sr_tab   = 8'b01000000;
    wrdy_tab = 8'b11100000;
    ard_tab  = '{0, 1, 1, 0, 1, 0, 0, 0};

    rst = 1'b1;
    bus.current_state = 3'd0;
    bus.cfg_wr_len = 10'd7;
    bus.cfg_rd_len = 8'd3;
    bus.cfg_rd_rep = 4'd2;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    #1;
    chk_reset_state();
    rst = 1'b0;

    // Single fill of 8 beats with reads gated off by current_state
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_addr_wr", 32'(bus.addr_wr), 32'(i));
      chk("fill_wr_en", 32'(bus.wr_en), 1);
      chk("fill_rd_gated", 32'(bus.rd_en), 0);
      tick();
    end
    bus.wr_valid = 1'b0;
    #1;
    chk("fill_load_done", 32'(bus.load_done), 1);
    chk("fill_bank_full", 32'(bus.bank_full), 1);
    chk("fill_wr_bank", 32'(bus.wr_bank), PP ? 1 : 0);
    chk("fill_addr_wr_wrap", 32'(bus.addr_wr), 0);
    chk("fill_wr_ready", 32'(bus.wr_ready), PP ? 1 : 0);
    tick();
    #1;
    chk("fill_load_done_pulse", 32'(bus.load_done), 0);
    tick();

    // Replay: 4 words x 3 passes, RD_LAT=2
    bus.current_state = 3'd2;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rep_rd_en", 32'(bus.rd_en), 1);
      chk("rep_addr_rd", 32'(bus.addr_rd), 32'(k % 4));
      chk("rep_valid", 32'(bus.weight_valid_rd), 32'(k >= 2));
      chk("rep_state_rst", 32'(bus.state_rst), 0);
      tick();
    end
    #1;
    chk("rep_bank_full", 32'(bus.bank_full), 0);
    chk("rep_rd_bank", 32'(bus.rd_bank), PP ? 1 : 0);
    chk("rep_rd_en_off", 32'(bus.rd_en), 0);
    chk("rep_valid_11", 32'(bus.weight_valid_rd), 1);
    chk("rep_state_rst_early", 32'(bus.state_rst), 0);
    chk("rep_wr_ready", 32'(bus.wr_ready), 1);
    tick();
    #1;
    chk("rep_valid_12", 32'(bus.weight_valid_rd), 1);
    chk("rep_state_rst", 32'(bus.state_rst), 1);
    tick();
    #1;
    chk("rep_valid_done", 32'(bus.weight_valid_rd), 0);
    chk("rep_state_rst_pulse", 32'(bus.state_rst), 0);
    tick();

    // Overlap: 4-beat fills, 2 words x 2 passes per bank, continuous traffic
    bus.cfg_wr_len = 10'd3;
    bus.cfg_rd_len = 8'd1;
    bus.cfg_rd_rep = 4'd1;
    bus.wr_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      logic e_wen, e_ren, e_wb, e_rb, e_ld, e_wv;
      int   e_aw, e_ar;
      if (PP) begin
        e_wen = 1'b1;
        e_aw  = t % 4;
        e_wb  = (t < 4 || t >= 8);
        e_ren = (t >= 4);
        e_rb  = (t < 8);
        e_ld  = (t == 4 || t == 8);
        e_wv  = (t >= 6);
      end else begin
        e_wen = (t < 4 || t >= 8);
        e_aw  = (t < 4) ? t : ((t < 8) ? 0 : t - 8);
        e_wb  = 1'b0;
        e_ren = (t >= 4 && t < 8);
        e_rb  = 1'b0;
        e_ld  = (t == 4);
        e_wv  = (t >= 6 && t < 10);
      end
      e_ar = e_ren ? t % 2 : 0;
      #1;
      chk("ovl_wr_en", 32'(bus.wr_en), 32'(e_wen));
      chk("ovl_addr_wr", 32'(bus.addr_wr), 32'(e_aw));
      chk("ovl_wr_bank", 32'(bus.wr_bank), 32'(e_wb));
      chk("ovl_rd_en", 32'(bus.rd_en), 32'(e_ren));
      chk("ovl_rd_bank", 32'(bus.rd_bank), 32'(e_rb));
      chk("ovl_addr_rd", 32'(bus.addr_rd), 32'(e_ar));
      chk("ovl_load_done", 32'(bus.load_done), 32'(e_ld));
      chk("ovl_valid", 32'(bus.weight_valid_rd), 32'(e_wv));
      chk("ovl_state_rst", 32'(bus.state_rst), 32'(t == 9));
      tick();
    end
    bus.wr_valid = 1'b0;
    repeat (20) tick();
    #1;
    chk("ovl_drain_full", 32'(bus.bank_full), 0);
    chk("ovl_drain_rd_bank", 32'(bus.rd_bank), 0);
    chk("ovl_drain_wr_bank", 32'(bus.wr_bank), 0);
    tick();

    // Backpressure: fill every bank with reads gated off
    bus.current_state = 3'd0;
    bus.wr_valid = 1'b1;
    repeat (10) tick();
    #1;
    chk("bp_bank_full", 32'(bus.bank_full), PP ? 3 : 1);
    chk("bp_wr_ready", 32'(bus.wr_ready), 0);
    chk("bp_wr_en", 32'(bus.wr_en), 0);
    chk("bp_addr_wr", 32'(bus.addr_wr), 0);
    chk("bp_wr_bank", 32'(bus.wr_bank), 0);
    tick();

    // Read stall pattern 1,0,1,1,1 then idle
    bus.current_state = 3'd2;
    for (int u = 0; u < 8; u++) begin
      bus.rd_ready = rr_tab[u];
      #1;
      chk("bp_rd_en", 32'(bus.rd_en), 32'(rr_tab[u]));
      chk("bp_addr_rd", 32'(bus.addr_rd), 32'(ard_tab[u]));
      chk("bp_valid", 32'(bus.weight_valid_rd), 32'(wv_tab[u]));
      chk("bp_state_rst", 32'(bus.state_rst), 32'(sr_tab[u]));
      chk("bp_wr_ready_hold", 32'(bus.wr_ready), 32'(wrdy_tab[u]));
      tick();
    end
    #1;
    chk("bp_post_full", 32'(bus.bank_full), PP ? 2 : 0);
    chk("bp_post_addr_wr", 32'(bus.addr_wr), 3);

    // Reset mid-stream with traffic in flight
    bus.rd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk_reset_state();
    tick();
    tick();
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("post_rst_state_rst", 32'(bus.state_rst), 0);
      chk("post_rst_valid", 32'(bus.weight_valid_rd), 0);
      tick();
    end

    // Zero-length configuration: every beat and pass is the last one
    bus.cfg_wr_len = 10'd0;
    bus.cfg_rd_len = 8'd0;
    bus.cfg_rd_rep = 4'd0;
    bus.wr_valid = 1'b1;
    #1;
    chk("zero_wr_en", 32'(bus.wr_en), 1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    chk("zero_load_done", 32'(bus.load_done), 1);
    chk("zero_bank_full", 32'(bus.bank_full), 1);
    chk("zero_addr_wr", 32'(bus.addr_wr), 0);
    tick();
    bus.rd_ready = 1'b1;
    #1;
    chk("zero_rd_en", 32'(bus.rd_en), 1);
    tick();
    bus.rd_ready = 1'b0;
    #1;
    chk("zero_rd_release", 32'(bus.bank_full), 0);
    chk("zero_addr_rd", 32'(bus.addr_rd), 0);
    tick();
    #1;
    chk("zero_valid", 32'(bus.weight_valid_rd), 1);
    chk("zero_state_rst", 32'(bus.state_rst), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
